// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, the canonical NOP and the
// sequential PC step.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        HOLD      = 3'd3,
        TRAP      = 3'd4
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          PC_STEP  = 4;

endpackage

// File: rtl/cpu_control_signals.sv
// Control bundle from the decoder; the fetch unit reads the PC-steering bits
// through the datapath modport.
interface cpu_control_signals;

    logic Jump;
    logic Branch;
    logic InverseBranch;
    logic PCOffset;

    modport control  (output Jump, output Branch, output InverseBranch, output PCOffset);
    modport datapath (input  Jump, input  Branch, input  InverseBranch, input  PCOffset);

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection (sequential / branch / jal / jalr).
// Build option MISALIGN_TRAP_EN: report misaligned targets instead of clearing bits [1:0].
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            jump,
    input  logic            branch,
    input  logic            inverse_branch,
    input  logic            pc_offset,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    logic            w_taken;
    logic [XLEN-1:0] w_target;

    always_comb begin
        w_taken = branch & (alu_zero ^ inverse_branch);
        // Jump outranks Branch; jalr drops bit 0 of the computed address.
        if (jump && pc_offset) begin
            w_target = alu_result & ~XLEN'(1);
        end else if (jump || w_taken) begin
            w_target = pc + imm;
        end else begin
            w_target = pc + XLEN'(PC_STEP);
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign next_pc  = w_target;
    assign misalign = |w_target[1:0];
`else
    assign next_pc  = w_target & ~XLEN'(3);
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// PC owner and single-outstanding instruction fetcher feeding decode.
// Build option MISALIGN_TRAP_EN: misaligned next PC parks the unit in TRAP until reset.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    cpu_control_signals.datapath        ctrl,
    input  logic                        alu_zero,
    input  logic [XLEN-1:0]             alu_result,
    input  logic [XLEN-1:0]             imm,
    output logic                        imem_req,
    output logic [XLEN-1:0]             imem_addr,
    input  logic                        imem_ready,
    input  logic                        imem_rvalid,
    input  logic [31:0]                 imem_rdata,
    output logic [31:0]                 inst_out,
    output logic                        inst_valid,
    input  logic                        inst_ready,
    output logic [XLEN-1:0]             pc_out,
    output logic [XLEN-1:0]             pc_plus4,
    output logic                        misaligned
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [31:0]     r_inst;
    logic [31:0]     w_inst_next;
    logic [XLEN-1:0] w_next_pc;
    logic            w_misalign;

    next_pc_calc #(
        .XLEN (XLEN)
    ) u_next_pc_calc (
        .pc             (r_pc),
        .imm            (imm),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .jump           (ctrl.Jump),
        .branch         (ctrl.Branch),
        .inverse_branch (ctrl.InverseBranch),
        .pc_offset      (ctrl.PCOffset),
        .next_pc        (w_next_pc),
        .misalign       (w_misalign)
    );

`ifdef MISALIGN_TRAP_EN
    logic r_misaligned;
    logic w_misaligned_next;
`endif

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_inst_next  = r_inst;
`ifdef MISALIGN_TRAP_EN
        w_misaligned_next = r_misaligned;
`endif
        case (r_state)
            IDLE: w_state_next = FETCH;
            FETCH: begin
                // Any rvalid seen here belongs to an abandoned request.
                if (imem_ready) begin
                    w_state_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (imem_rvalid) begin
                    w_inst_next  = imem_rdata;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (inst_ready) begin
`ifdef MISALIGN_TRAP_EN
                    if (w_misalign) begin
                        w_misaligned_next = 1'b1;
                        w_state_next      = TRAP;
                    end else begin
                        w_pc_next    = w_next_pc;
                        w_state_next = FETCH;
                    end
`else
                    w_pc_next    = w_next_pc;
                    w_state_next = FETCH;
`endif
                end
            end
            TRAP:    w_state_next = TRAP;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= NOP_INST;
`ifdef MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_inst  <= w_inst_next;
`ifdef MISALIGN_TRAP_EN
            r_misaligned <= w_misaligned_next;
`endif
        end
    end

    assign imem_req   = (r_state == FETCH);
    assign imem_addr  = r_pc;
    assign inst_valid = (r_state == HOLD);
    assign inst_out   = r_inst;
    assign pc_out     = r_pc;
    assign pc_plus4   = r_pc + XLEN'(PC_STEP);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = r_misaligned;
`else
    assign misaligned = w_misalign;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed PC-steering cases, mid-fetch reset,
// then randomized traffic against a behavioural next-PC model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_zero = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] imm = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misaligned;

    cpu_control_signals ctrl_if ();

    fetch_pc_unit #(
        .XLEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl        (ctrl_if.datapath),
        .alu_zero    (alu_zero),
        .alu_result  (alu_result),
        .imm         (imm),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_out    (inst_out),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_inst_t;

    exp_inst_t   exp_inst_q[$];
    logic [31:0] exp_fetch_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc = RESET_PC;
    bit          model_trap = 0;
    bit          mem_pending = 0;
    bit          mem_stale = 0;
    int          mem_cnt = 0;
    int          mem_mode = 0;   // 0: ready, 1-cycle data; 1: random; 2: ready, 4-cycle data

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: where the program goes after this instruction retires.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input bit j, b, inv, po, z,
                                             input logic [31:0] im, alu, output bit mis);
        logic [31:0] t;
        if (j && po)                t = {alu[31:1], 1'b0};
        else if (j)                 t = pc + im;
        else if (b && (z != inv))   t = pc + im;
        else                        t = pc + 32'd4;
        mis = (t % 4) != 0;
`ifdef MISALIGN_TRAP_EN
        return t;
`else
        return t - (t % 4);
`endif
    endfunction

    task automatic drive_random_ctrl();
        ctrl_if.Jump          = 1'($urandom);
        ctrl_if.Branch        = 1'($urandom);
        ctrl_if.InverseBranch = 1'($urandom);
        ctrl_if.PCOffset      = 1'($urandom);
        alu_zero              = 1'($urandom);
        imm                   = $urandom;
        alu_result            = $urandom;
    endtask

    // Memory responder: one outstanding read, optional spurious rvalid when idle.
    initial begin
        exp_inst_t e;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (mem_pending) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    mem_pending = 0;
                    if (!mem_stale) begin
                        e.inst = imem_rdata;
                        e.pc   = model_pc;
                        exp_inst_q.push_back(e);
                    end
                end
            end else if (mem_mode == 1 && $urandom_range(0, 7) == 0) begin
                imem_rvalid = 1'b1;
            end
            imem_ready = (mem_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (rst && mem_pending) mem_stale = 1;
            if (!rst && imem_req && imem_ready) begin
                mem_pending = 1;
                mem_stale   = 0;
                mem_cnt     = (mem_mode == 0) ? 1 : (mem_mode == 2) ? 4 : $urandom_range(1, 3);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a handshake.
    initial begin
        logic [31:0] prev_inst;
        logic [31:0] prev_pc;
        logic [31:0] ea;
        bit          hold_prev;
        exp_inst_t   e;
        hold_prev = 0;
        prev_inst = '0;
        prev_pc   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold_prev = 0;
            end else begin
                if (imem_req && imem_ready) begin
                    if (exp_fetch_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fetch_unexpected actual=%h required=no_fetch", imem_addr);
                    end else begin
                        ea = exp_fetch_q.pop_front();
                        check("fetch_addr", imem_addr, ea);
                    end
                end
                if (inst_valid) begin
                    check("no_req_in_hold", 32'(imem_req), 32'd0);
                    if (hold_prev) begin
                        check("inst_stable", inst_out, prev_inst);
                        check("pc_stable", pc_out, prev_pc);
                    end
                end
                if (inst_valid && inst_ready) begin
                    if (exp_inst_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL accept_unexpected actual=%h required=no_inst", inst_out);
                    end else begin
                        e = exp_inst_q.pop_front();
                        check("inst_out", inst_out, e.inst);
                        check("pc_out", pc_out, e.pc);
                        check("pc_plus4", pc_plus4, e.pc + 32'd4);
                    end
                    $display("ACCEPT pc=%h inst=%h j=%0b b=%0b inv=%0b po=%0b z=%0b imm=%h alu=%h",
                             pc_out, inst_out, ctrl_if.Jump, ctrl_if.Branch, ctrl_if.InverseBranch,
                             ctrl_if.PCOffset, alu_zero, imm, alu_result);
                end
                hold_prev = inst_valid && !inst_ready;
                prev_inst = inst_out;
                prev_pc   = pc_out;
            end
        end
    end

    // Retire one instruction with the given control and operands.
    task automatic do_inst(input bit j, b, inv, po, z, input logic [31:0] im, alu, input int stall);
        int          n;
        bit          mis;
        logic [31:0] nx;
        n = 0;
        inst_ready = 1'b0;
        while (!inst_valid && n < 300) begin
            @(negedge clk);
            drive_random_ctrl();
            #1;
            n++;
        end
        if (!inst_valid) begin
            checks++;
            errors++;
            $display("FAIL inst_valid_timeout actual=0 required=1");
            return;
        end
        repeat (stall) begin
            @(negedge clk);
            drive_random_ctrl();
            #1;
        end
        @(negedge clk);
        ctrl_if.Jump          = j;
        ctrl_if.Branch        = b;
        ctrl_if.InverseBranch = inv;
        ctrl_if.PCOffset      = po;
        alu_zero              = z;
        imm                   = im;
        alu_result            = alu;
        inst_ready            = 1'b1;
        #1;
        nx = ref_next(model_pc, j, b, inv, po, z, im, alu, mis);
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
            model_trap = 1;
        end else begin
            exp_fetch_q.push_back(nx);
            model_pc = nx;
        end
`else
        exp_fetch_q.push_back(nx);
        model_pc = nx;
`endif
        @(negedge clk);
        inst_ready = 1'b0;
        drive_random_ctrl();
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst        = 1'b1;
        inst_ready = 1'b0;
        mem_mode   = 0;
        exp_fetch_q.delete();
        exp_inst_q.delete();
        @(negedge clk);
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_out", inst_out, NOP);
        check("rst_pc_out", pc_out, RESET_PC);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        @(negedge clk);
        model_pc   = RESET_PC;
        model_trap = 0;
        exp_fetch_q.push_back(RESET_PC);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit j, b;
        logic [31:0] r_imm, r_alu;
        ctrl_if.Jump = 0; ctrl_if.Branch = 0; ctrl_if.InverseBranch = 0; ctrl_if.PCOffset = 0;
        exp_fetch_q.push_back(RESET_PC);
        repeat (3) @(negedge clk);
        #1;
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_inst_valid", 32'(inst_valid), 32'd0);
        check("reset_inst_out", inst_out, NOP);
        check("reset_pc_out", pc_out, RESET_PC);
        check("reset_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        check("reset_misaligned", 32'(misaligned), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            #1;
            n++;
            if (inst_valid) break;
        end
        check("first_valid_latency", n, 3);

        // Directed steering: j b inv po z imm alu stall
        do_inst(0, 0, 0, 0, 0, 32'h0,         32'h0,         0);  // 0 -> 4
        do_inst(0, 0, 0, 0, 0, 32'h0,         32'h0,         0);  // 4 -> 8
        do_inst(0, 1, 0, 0, 1, 32'h10,        32'h0,         0);  // beq taken -> 0x18
        do_inst(1, 0, 0, 1, 0, 32'h0,         32'h9,         0);  // jalr -> 0x8
        do_inst(0, 1, 0, 0, 0, 32'h10,        32'h0,         0);  // beq not taken -> 0xC
        do_inst(1, 0, 0, 1, 0, 32'h0,         32'h8,         0);  // jalr -> 0x8
        do_inst(0, 1, 1, 0, 0, 32'h10,        32'h0,         0);  // bne taken -> 0x18
        do_inst(1, 0, 0, 1, 0, 32'h0,         32'h41,        0);  // jalr -> 0x40
        do_inst(1, 0, 0, 1, 0, 32'h0,         32'h1235,      0);  // jalr -> 0x1234
        do_inst(1, 0, 0, 1, 0, 32'h0,         32'h40,        0);  // jalr -> 0x40
        do_inst(1, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0,         0);  // jal back -> 0x30
        do_inst(1, 1, 0, 0, 0, 32'h20,        32'h0,         0);  // jump beats untaken branch -> 0x50
        do_inst(1, 0, 0, 1, 0, 32'h0,         32'hFFFF_FFFC, 0);  // jalr -> top of space
        do_inst(0, 0, 0, 0, 0, 32'h0,         32'h0,         0);  // wrap -> 0
        mem_mode = 2;
        do_inst(0, 0, 0, 0, 0, 32'h0,         32'h0,         5);  // long stall in HOLD -> 4

        // Reset while the read is outstanding; its late rvalid must be dropped.
        n = 0;
        while (!mem_pending && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("pending_before_reset", 32'(mem_pending), 32'd1);
        reset_dut();
        do_inst(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);  // fresh fetch at RESET_PC -> 4
        do_inst(1, 0, 0, 1, 0, 32'h0, 32'h0, 0);  // jalr -> 0

`ifdef MISALIGN_TRAP_EN
        do_inst(1, 0, 0, 0, 0, 32'h2, 32'h0, 0);  // jal to pc+2 traps
        check("trap_model", 32'(model_trap), 32'd1);
        repeat (10) begin
            @(negedge clk);
            #1;
            check("trap_misaligned", 32'(misaligned), 32'd1);
            check("trap_no_req", 32'(imem_req), 32'd0);
        end
        reset_dut();
`else
        do_inst(1, 0, 0, 0, 0, 32'h2, 32'h0, 0);  // jal to pc+2, low bits cleared
        check("no_trap_misaligned", 32'(misaligned), 32'd0);
`endif

        mem_mode = 1;
        for (int i = 0; i < 150; i++) begin
            j     = ($urandom_range(0, 3) == 0);
            b     = ($urandom_range(0, 2) == 0);
            r_imm = $urandom_range(0, 1) ? $urandom : 32'($signed(16'($urandom)));
            r_alu = $urandom;
`ifdef MISALIGN_TRAP_EN
            r_imm = r_imm & ~32'd3;
            r_alu = r_alu & ~32'd2;
`endif
            do_inst(j, b, 1'($urandom), 1'($urandom), 1'($urandom), r_imm, r_alu, $urandom_range(0, 3));
        end
        check("final_misaligned", 32'(misaligned), 32'd0);
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch and PC-sequencing block on the consumer side of cpu_control_signals. It connects through the datapath modport and uses only Jump, Branch, InverseBranch and PCOffset.
- Owns the PC register, fetches one instruction at a time over a req/ready + rvalid memory handshake, and presents each instruction to decode with a valid/ready handshake.
- On each decode accept it computes the next PC: sequential, branch, jal or jalr.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- ctrl  interface  -  cpu_control_signals.datapath; uses Jump, Branch, InverseBranch, PCOffset.
- alu_zero  input  1  ALU zero flag for the instruction on inst_out.
- alu_result  input  XLEN  ALU result; jalr target.
- imm  input  XLEN  immediate from immgen for the instruction on inst_out.
- imem_req  output  1  fetch request.
- imem_addr  output  XLEN  fetch address; held stable while imem_req=1.
- imem_ready  input  1  memory accepts request.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read data.
- inst_out  output  32  instruction to decode.
- inst_valid  output  1  inst_out valid.
- inst_ready  input  1  decode/execute accepts (instruction retires).
- pc_out  output  XLEN  PC of inst_out.
- pc_plus4  output  XLEN  pc_out+4; link value for jal/jalr.
- misaligned  output  1  next-PC misalignment trap (MISALIGN_TRAP_EN only; tied 0 otherwise).

Behaviour:
- FSM states: IDLE, FETCH, WAIT_DATA, HOLD, TRAP (TRAP exists only with the feature enabled).
- Reset values:
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, inst_valid=0, inst_out=32'h0000_0013 (nop).
  - misaligned=0.
- IDLE -> FETCH unconditionally on the next cycle after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_req && imem_ready -> WAIT_DATA. imem_rvalid in the same cycle is ignored.
- WAIT_DATA:
  - On imem_rvalid, latch imem_rdata into inst_out -> HOLD.
  - inst_valid=1 from the following cycle.
  - Minimum fetch latency: ready in cycle N, rvalid in N+1, inst_valid in N+2.
- HOLD:
  - inst_valid=1; inst_out and pc_out stable until inst_ready=1.
  - On inst_valid && inst_ready: pc <= next_pc, inst_valid <= 0, -> FETCH.
- next_pc, evaluated in the accept cycle from the current ctrl/alu_zero/alu_result/imm:
  - taken = Branch & (alu_zero ^ InverseBranch).
  - Jump & PCOffset: next_pc = alu_result & ~1 (jalr).
  - Jump & !PCOffset: next_pc = pc + imm (jal).
  - !Jump & taken: next_pc = pc + imm.
  - Otherwise: next_pc = pc + 4.
  - Jump has priority over Branch.
- Arithmetic: XLEN-bit modulo add; wrap from 32'hFFFF_FFFC to 0 is legal.
- pc_plus4 = pc + 4, combinational.
- imem_rvalid outside WAIT_DATA is ignored, including stale data after reset.
- Reset mid-operation (any state): returns to IDLE next cycle; the outstanding fetch is abandoned.
- One outstanding fetch only; no prefetch, no flush input. Redirect is implicit because fetch starts after accept.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Enabled:
  - If next_pc[1:0] != 0 at accept, pc is not updated.
  - State -> TRAP and misaligned=1, sticky.
  - No further imem_req; only rst exits TRAP.
- Disabled:
  - next_pc[1:0] is forced to 2'b00.
  - misaligned tied 0.
  - TRAP state absent.

Decomposition:
- Shared package cpu_pkg holds:
  - enum fetch_state_t {IDLE, FETCH, WAIT_DATA, HOLD, TRAP}.
  - localparam NOP_INST = 32'h0000_0013.
  - localparam PC_STEP = 4.
- Sub-module next_pc_calc: purely combinational. Inputs: pc, imm, alu_result, alu_zero and the four ctrl bits. Outputs: next_pc, misalign.
- fetch_pc_unit keeps the FSM and registers.

Test Plan:
- Reset, RESET_PC=0, memory ready=1, rvalid one cycle later -> imem_addr=0, then 4, then 8 for three accepted non-control instructions; inst_valid first rises 3 cycles after rst falls.
- Accept with Branch=1, InverseBranch=0, alu_zero=1, imm=0x10 at pc=0x8 -> next imem_addr=0x18. Same with alu_zero=0 -> 0xC. With InverseBranch=1 and alu_zero=0 -> 0x18.
- Jump=1, PCOffset=1, alu_result=0x1235 at pc=0x40 -> imem_addr=0x1234 and pc_plus4=0x44 during HOLD. With PCOffset=0 and imm=0xFFFF_FFF0 -> imem_addr=0x30.
- Hold inst_ready=0 for 5 cycles in HOLD with imem_ready held low in between -> inst_out, pc_out stable, no imem_req. Assert rst during WAIT_DATA, then a stale rvalid -> ignored; fetch restarts at RESET_PC.
- With MISALIGN_TRAP_EN: jal with imm=0x2 -> misaligned=1, imem_req stays 0 for 10 cycles until rst. Without the macro: same stimulus -> imem_addr = pc+0x0 (low bits cleared).
- pc=0xFFFF_FFFC sequential accept -> imem_addr=0x0000_0000.
